// File: rtl/dice_sequencer.sv
// rtl/dice_sequencer.sv - registered up/down table sequencer with wrap/saturate ends, index load and self-timed bursts
// value is always the table entry at idx; both are registered on the same edge.
module dice_sequencer #(
  parameter int LEN = 6,
  parameter int WIDTH = 3,
  parameter logic [LEN*WIDTH-1:0] PATTERN = 18'h16ADB,
  parameter int CW = 8,
  localparam int IW = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             down,
  input  logic             wrap,
  input  logic             load,
  input  logic [IW-1:0]    load_idx,
  input  logic             burst_start,
  input  logic [CW-1:0]    burst_len,
  output logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             at_end
);

  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [IW-1:0]    idx_next, idx_step;
  logic             done_next;
  logic [WIDTH-1:0] table_mem [LEN];

  for (genvar g = 0; g < LEN; g++) begin : g_table
    assign table_mem[g] = PATTERN[g*WIDTH +: WIDTH];
  end

  // Ends either wrap to the opposite end or hold, depending on wrap.
  always_comb begin
    idx_step = idx;
    if (!down) begin
      if (idx == LAST) idx_step = wrap ? '0 : LAST;
      else             idx_step = idx + 1'b1;
    end else begin
      if (idx == '0)   idx_step = wrap ? LAST : '0;
      else             idx_step = idx - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    done_next  = 1'b0;
    if (load) begin
      idx_next   = (load_idx > LAST) ? LAST : load_idx;
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (burst_start) begin
            if (burst_len == '0) begin
              done_next = 1'b1;
            end else begin
              state_next = RUN;
              cnt_next   = burst_len;
            end
          end else if (en) begin
            idx_next = idx_step;
          end
        end
        RUN: begin
          idx_next = idx_step;
          cnt_next = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      value <= table_mem[0];
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      value <= table_mem[idx_next];
      done  <= done_next;
    end
  end

  assign busy   = (state == RUN);
  assign at_end = down ? (idx == '0) : (idx == LAST);

endmodule

// File: tb/tb_dice_sequencer.sv
// tb/tb_dice_sequencer.sv - directed-vector bench for dice_sequencer (default and LEN=10/WIDTH=4 instances)
module tb_dice_sequencer;

  logic       clk = 1'b0;
  logic       reset, en, down, wrap, load, burst_start;
  logic [2:0] load_idx;
  logic [7:0] burst_len;
  logic [2:0] idx;
  logic [2:0] value;
  logic       busy, done, at_end;

  logic       b_en, b_down, b_wrap, b_load, b_burst_start;
  logic [3:0] b_load_idx;
  logic [7:0] b_burst_len;
  logic [3:0] b_idx;
  logic [3:0] b_value;
  logic       b_busy, b_done, b_at_end;

  int vectors = 0;
  int errors  = 0;

  // Default table entries 0..5 and the override table entries 0..9.
  int pat6 [6]  = '{3, 3, 3, 5, 6, 2};
  int pat10 [10] = '{1, 4, 7, 10, 13, 0, 3, 6, 9, 12};

  always #5 clk = ~clk;

  dice_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .down(down), .wrap(wrap),
    .load(load), .load_idx(load_idx), .burst_start(burst_start), .burst_len(burst_len),
    .idx(idx), .value(value), .busy(busy), .done(done), .at_end(at_end)
  );

  dice_sequencer #(.LEN(10), .WIDTH(4), .PATTERN(40'hC9630DA741), .CW(8)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .down(b_down), .wrap(b_wrap),
    .load(b_load), .load_idx(b_load_idx), .burst_start(b_burst_start), .burst_len(b_burst_len),
    .idx(b_idx), .value(b_value), .busy(b_busy), .done(b_done), .at_end(b_at_end)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx); end
    vectors++; if (value !== 3'd3) begin errors++; $display("FAIL reset_value got %0d want 3", value); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    vectors++; if (b_idx !== 4'd0) begin errors++; $display("FAIL reset_b_idx got %0d want 0", b_idx); end
  endtask

  task automatic test_up_wrap();
    int exp_idx [7] = '{1, 2, 3, 4, 5, 0, 1};
    en = 1'b1; down = 1'b0; wrap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++; if (idx !== 3'(exp_idx[i])) begin errors++; $display("FAIL up_wrap_idx step %0d got %0d want %0d", i, idx, exp_idx[i]); end
      vectors++; if (value !== 3'(pat6[exp_idx[i]])) begin errors++; $display("FAIL up_wrap_value step %0d got %0d want %0d", i, value, pat6[exp_idx[i]]); end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    wrap = 1'b0; down = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (idx !== 3'd0) begin errors++; $display("FAIL saturate_idx step %0d got %0d want 0", i, idx); end
      vectors++; if (at_end !== 1'b1) begin errors++; $display("FAIL saturate_at_end step %0d got %0b want 1", i, at_end); end
      vectors++; if (value !== 3'd3) begin errors++; $display("FAIL saturate_value step %0d got %0d want 3", i, value); end
    end
    en = 1'b0;
  endtask

  task automatic test_burst();
    int exp_idx [4] = '{4, 5, 0, 1};
    int exp_busy [4] = '{1, 1, 1, 0};
    int exp_done [4] = '{0, 0, 0, 1};
    load = 1'b1; load_idx = 3'd4;
    tick();
    load = 1'b0;
    vectors++; if (idx !== 3'd4 || value !== 3'd6) begin errors++; $display("FAIL burst_preload got idx %0d value %0d want idx 4 value 6", idx, value); end
    down = 1'b0; wrap = 1'b1; burst_start = 1'b1; burst_len = 8'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      burst_start = 1'b0;
      vectors++; if (idx !== 3'(exp_idx[i])) begin errors++; $display("FAIL burst_idx cycle %0d got %0d want %0d", i, idx, exp_idx[i]); end
      vectors++; if (busy !== 1'(exp_busy[i])) begin errors++; $display("FAIL burst_busy cycle %0d got %0b want %0d", i, busy, exp_busy[i]); end
      vectors++; if (done !== 1'(exp_done[i])) begin errors++; $display("FAIL burst_done cycle %0d got %0b want %0d", i, done, exp_done[i]); end
      vectors++; if (value !== 3'(pat6[exp_idx[i]])) begin errors++; $display("FAIL burst_value cycle %0d got %0d want %0d", i, value, pat6[exp_idx[i]]); end
    end
    tick();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL burst_done_clear got %0b want 0", done); end
  endtask

  task automatic test_zero_burst_and_ignored();
    int exp_idx [5] = '{1, 2, 3, 4, 5};
    burst_start = 1'b1; burst_len = 8'd0;
    tick();
    burst_start = 1'b0;
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL zero_burst_done got %0b want 1", done); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_burst_busy got %0b want 0", busy); end
    vectors++; if (idx !== 3'd1) begin errors++; $display("FAIL zero_burst_idx got %0d want 1", idx); end
    tick();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_burst_after got done %0b busy %0b want 0 0", done, busy); end
    burst_start = 1'b1; burst_len = 8'd4;
    tick();
    burst_len = 8'd2; en = 1'b1;
    vectors++; if (idx !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL ignored_accept got idx %0d busy %0b want 1 1", idx, busy); end
    for (int i = 1; i < 5; i++) begin
      tick();
      vectors++; if (idx !== 3'(exp_idx[i])) begin errors++; $display("FAIL ignored_idx cycle %0d got %0d want %0d", i, idx, exp_idx[i]); end
      vectors++; if (busy !== (i < 4)) begin errors++; $display("FAIL ignored_busy cycle %0d got %0b want %0b", i, busy, (i < 4)); end
      vectors++; if (done !== (i == 4)) begin errors++; $display("FAIL ignored_done cycle %0d got %0b want %0b", i, done, (i == 4)); end
    end
    burst_start = 1'b0; en = 1'b0;
    tick();
    vectors++; if (done !== 1'b0 || idx !== 3'd5) begin errors++; $display("FAIL ignored_after got done %0b idx %0d want 0 5", done, idx); end
  endtask

  task automatic test_load_abort_clamp();
    down = 1'b0; wrap = 1'b1; burst_start = 1'b1; burst_len = 8'd5;
    tick();
    burst_start = 1'b0;
    tick();
    tick();
    vectors++; if (idx !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre got idx %0d busy %0b want 1 1", idx, busy); end
    load = 1'b1; load_idx = 3'd2;
    tick();
    load = 1'b0;
    vectors++; if (idx !== 3'd2 || value !== 3'd3) begin errors++; $display("FAIL abort_idx got idx %0d value %0d want 2 3", idx, value); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags got busy %0b done %0b want 0 0", busy, done); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (done !== 1'b0 || idx !== 3'd2) begin errors++; $display("FAIL abort_quiet cycle %0d got done %0b idx %0d want 0 2", i, done, idx); end
    end
    load = 1'b1; load_idx = 3'd7;
    tick();
    load = 1'b0;
    vectors++; if (idx !== 3'd5 || value !== 3'd2) begin errors++; $display("FAIL clamp got idx %0d value %0d want 5 2", idx, value); end
    vectors++; if (at_end !== 1'b1) begin errors++; $display("FAIL clamp_at_end got %0b want 1", at_end); end
  endtask

  task automatic test_back_to_back();
    load = 1'b1; load_idx = 3'd0;
    tick();
    load = 1'b0; down = 1'b0; wrap = 1'b1; burst_start = 1'b1; burst_len = 8'd1;
    tick();
    vectors++; if (busy !== 1'b1 || idx !== 3'd0) begin errors++; $display("FAIL b2b_accept got busy %0b idx %0d want 1 0", busy, idx); end
    tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b1 || idx !== 3'd1) begin errors++; $display("FAIL b2b_done1 got busy %0b done %0b idx %0d want 0 1 1", busy, done, idx); end
    tick();
    burst_start = 1'b0;
    vectors++; if (busy !== 1'b1 || done !== 1'b0 || idx !== 3'd1) begin errors++; $display("FAIL b2b_reaccept got busy %0b done %0b idx %0d want 1 0 1", busy, done, idx); end
    tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b1 || idx !== 3'd2) begin errors++; $display("FAIL b2b_done2 got busy %0b done %0b idx %0d want 0 1 2", busy, done, idx); end
    tick();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_clear got %0b want 0", done); end
  endtask

  task automatic test_reset_mid_burst();
    burst_start = 1'b1; burst_len = 8'd5;
    tick();
    burst_start = 1'b0;
    tick();
    vectors++; if (idx !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got idx %0d busy %0b want 3 1", idx, busy); end
    reset = 1'b1; en = 1'b1; load = 1'b1; load_idx = 3'd4;
    tick();
    reset = 1'b0; en = 1'b0; load = 1'b0;
    vectors++; if (idx !== 3'd0 || value !== 3'd3) begin errors++; $display("FAIL midrst_idx got idx %0d value %0d want 0 3", idx, value); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_flags got busy %0b done %0b want 0 0", busy, done); end
    tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || idx !== 3'd0) begin errors++; $display("FAIL midrst_after got busy %0b done %0b idx %0d want 0 0 0", busy, done, idx); end
  endtask

  task automatic test_param_override();
    int e;
    vectors++; if (b_idx !== 4'd0 || b_value !== 4'd1) begin errors++; $display("FAIL param_start got idx %0d value %0d want 0 1", b_idx, b_value); end
    b_en = 1'b1; b_down = 1'b0; b_wrap = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      e = i % 10;
      vectors++; if (b_idx !== 4'(e)) begin errors++; $display("FAIL param_idx step %0d got %0d want %0d", i, b_idx, e); end
      vectors++; if (b_value !== 4'(pat10[e])) begin errors++; $display("FAIL param_value step %0d got %0d want %0d", i, b_value, pat10[e]); end
      vectors++; if (b_at_end !== (e == 9)) begin errors++; $display("FAIL param_at_end step %0d got %0b want %0b", i, b_at_end, (e == 9)); end
    end
    b_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; down = 1'b0; wrap = 1'b0; load = 1'b0; load_idx = '0;
    burst_start = 1'b0; burst_len = '0;
    b_en = 1'b0; b_down = 1'b0; b_wrap = 1'b0; b_load = 1'b0; b_load_idx = '0;
    b_burst_start = 1'b0; b_burst_len = '0;
    test_reset();
    test_up_wrap();
    test_saturate();
    test_burst();
    test_zero_burst_and_ignored();
    test_load_abort_clamp();
    test_back_to_back();
    test_reset_mid_burst();
    test_param_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dice_sequencer.md
# dice_sequencer

Parametrised, registered up/down pattern sequencer. It steps through a LEN-entry table of WIDTH-bit output values (default table 3,3,3,5,6,2) in either direction. It adds a wrap or saturate end mode, direct index load, and a self-timed burst mode that makes N consecutive steps and then signals completion. It sits between the user-input debounce logic and the display/value decode stage, and it replaces the purely combinational next-state stage with owned state.

## Interface
Parameters:
- LEN, 6: number of table entries; must be ≥ 2.
- WIDTH, 3: bit width of each table value.
- PATTERN, 18'h16ADB: packed table of LEN*WIDTH bits. Entry i is PATTERN[i*WIDTH +: WIDTH]. The default decodes to entries 0..5 = 3,3,3,5,6,2.
- CW, 8: width of the burst-length counter.
- IW (localparam) = $clog2(LEN).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  single-step strobe, sampled each edge.
- down  in  1  step direction: 0 = index+1, 1 = index−1.
- wrap  in  1  end mode: 1 = wrap around, 0 = saturate at the ends.
- load  in  1  load index from load_idx.
- load_idx  in  IW  index to load; values ≥ LEN clamp to LEN−1.
- burst_start  in  1  start a burst of burst_len steps.
- burst_len  in  CW  number of steps in the burst; sampled only on an accepted burst_start.
- idx  out  IW  current table index (registered).
- value  out  WIDTH  table entry at idx (registered, updated on the same edge as idx).
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.
- at_end  out  1  combinational: idx==LEN−1 when down=0; idx==0 when down=1.

## Operation
- **Reset** (synchronous):
  - idx=0, value=PATTERN entry 0, busy=0, done=0, burst counter=0.
  - Reset overrides every other input.
- **Priority** per edge: reset > load > burst_start > en.
- **Step function**:
  - Up: next = idx+1. At idx=LEN−1, next = 0 if wrap=1, else next = LEN−1 (hold).
  - Down: next = idx−1. At idx=0, next = LEN−1 if wrap=1, else next = 0 (hold).
  - wrap and down are sampled on every step edge, including every burst step.
- **Load**:
  - idx ← min(load_idx, LEN−1), and value follows.
  - If busy, load aborts the burst: busy ← 0, counter ← 0, and done is not pulsed.
- **Burst state machine**, states IDLE/RUN:
  - IDLE + burst_start with burst_len=N>0: go to RUN, counter ← N, idx unchanged on this edge.
  - IDLE + burst_start with burst_len=0: stay IDLE, done ← 1 on this edge, no step.
  - RUN, each edge: one step, counter −1. When the counter goes 1→0: go to IDLE, busy ← 0, done ← 1.
  - RUN ignores en and burst_start.
- **done**: high for exactly one cycle; cleared on the following edge unless set again.
- **en** in IDLE: one step per edge it is high. Back-to-back strobes step every cycle.

## Timing
- Step latency: one cycle. An input sampled at edge t is visible on idx/value after edge t.
- Burst of N accepted at edge t:
  - busy=1 after edge t.
  - Steps occur at edges t+1 … t+N.
  - After edge t+N: busy=0 and done=1 for one cycle. Total N+1 cycles from accept to done.
- A new burst_start is accepted at the edge where done is high, i.e. immediately after busy falls.
- at_end has zero latency from down; it is only valid with a registered idx.
- value never differs from PATTERN[idx] on any cycle.

## Test plan
- **Reset and up-wrap**: reset, then en=1, down=0, wrap=1 for 7 cycles. Required: idx goes 0,1,2,3,4,5,0,1 and value goes 3,3,3,5,6,2,3,3.
- **Saturate**: wrap=0, down=1 from idx=1, en for 3 cycles. Required: idx 1→0→0→0; at_end=1 from idx=0 onward.
- **Burst**: idx=4, down=0, wrap=1, burst_start with burst_len=3. Required: busy for 3 cycles, idx 4→5→0→1, done pulse after the third step, busy=0 on the same cycle as done.
- **Zero burst and ignored inputs**: burst_len=0 gives done=1 on the next cycle, busy never set, idx unchanged. During a running burst, en and burst_start have no effect.
- **Load abort and clamp**: load with load_idx=2 mid-burst. Required: idx=2, busy=0, no done pulse. Then load with load_idx=7 (LEN=6). Required: idx=5, value=2.
- **Reset mid-burst and parameter override**: reset asserted mid-burst gives idx=0, busy=0, done=0 on the next cycle. Repeat the up-wrap case with LEN=10, WIDTH=4 and an arbitrary PATTERN; idx must wrap at 9.
